ram_ctrl: RTL
=============

# ram_ctrl

Request front-end for the single-port `ram` block: accepts valid/ready read and write requests, drives the RAM's write-enable, address and data-in, and returns read data through a one-entry valid/ready response slot. It sits directly upstream of `ram`, one instance per RAM. It optionally runs a hardware clear sequence that zeroes the entire RAM.

## Interface
- `ADDR_WIDTH`, 8, address width; RAM depth is 2^ADDR_WIDTH.
- `DATA_WIDTH`, 8, data word width.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when high with `req_valid`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  request address.
- `req_data`  in  DATA_WIDTH  write data; ignored for reads.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_data`  out  DATA_WIDTH  read data.
- `clr_start`  in  1  one-cycle clear request; present only with `RAM_CTRL_CLEAR_EN`.
- `clr_busy`  out  1  clear sequence running; present only with `RAM_CTRL_CLEAR_EN`.
- `ram_wr_en`  out  1  to `ram.wr_en`.
- `ram_addr`  out  ADDR_WIDTH  to `ram.addr`.
- `ram_d_in`  out  DATA_WIDTH  to `ram.d_in`.
- `ram_d_out`  in  DATA_WIDTH  from `ram.d_out`; this is an asynchronous read.

## Operation
- The FSM has two states: IDLE and CLEAR. CLEAR exists only with the macro.
- The response slot is free when `!rsp_valid || rsp_ready`.
- `req_ready` is asserted when all of the following hold: state is IDLE, the response slot is free, and `clr_start` is low.
- On an accepted write:
  - `ram_wr_en` = 1, `ram_addr` = `req_addr` and `ram_d_in` = `req_data`, combinationally in the same cycle.
  - The RAM updates at that edge.
- On an accepted read:
  - `ram_addr` = `req_addr`.
  - `rsp_data` <= `ram_d_out` at the edge, and `rsp_valid` <= 1.
- Response handshake:
  - Once `rsp_valid` rises, `rsp_valid` and `rsp_data` hold stable until `rsp_ready`.
  - On the `rsp_ready` edge, `rsp_valid` clears unless a new read is accepted in the same cycle. In that case the slot reloads with the new data and `rsp_valid` stays 1.
- When no request is accepted: `ram_wr_en` = 0. `ram_addr` and `ram_d_in` hold their last driven values, which are don't-care functionally.
- CLEAR sequence:
  - Entered on `clr_start` in IDLE. `clr_start` takes priority over a same-cycle request, which is not accepted.
  - An address counter runs from 0 to DEPTH-1, one word per cycle, with `ram_wr_en` = 1 and `ram_d_in` = 0.
  - The state returns to IDLE after the DEPTH-1 write. The counter wraps to 0.
  - `clr_start` is ignored while in CLEAR.
  - A pending response stays valid and drainable during CLEAR.
- Reset:
  - Outputs go to `req_ready` = 0 during reset, `rsp_valid` = 0, `rsp_data` = 0, `clr_busy` = 0, `ram_wr_en` = 0, `ram_addr` = 0 and `ram_d_in` = 0.
  - Reset mid-CLEAR aborts the sequence. The FSM returns to IDLE and RAM contents are left partially cleared.
  - Reset never touches RAM contents.

## Timing
- Write latency: data is visible at the RAM after the acceptance edge. A read accepted the next cycle returns the new value.
- Read latency: `rsp_valid` is high the cycle after acceptance.
- Throughput: one request per cycle when `rsp_ready` is held high.
- Clear duration: exactly DEPTH cycles with `clr_busy` high. `clr_busy` rises on the edge after `clr_start` and falls on the edge after the final write. `req_ready` resumes the following cycle.
- `req_ready` has a combinational dependency on `rsp_ready` and `clr_start`. `ram_*` outputs have a combinational dependency on `req_*`.

## Configuration
- `RAM_CTRL_CLEAR_EN` defined:
  - The `clr_start` and `clr_busy` ports, the CLEAR state and the address counter are built.
- `RAM_CTRL_CLEAR_EN` undefined:
  - The ports are absent and the FSM is IDLE only.
  - `req_ready` = `!rst_n ? 0 :` slot free.

## Structure
- Shared package `ram_ctrl_pkg` holds:
  - the state enum (IDLE, CLEAR);
  - the localparam for RAM depth derived from ADDR_WIDTH.
- No sub-module is required. The response slot and the clear counter are inline. `ram` is instantiated alongside at the next level up.

## Test plan
- Write 0xA5 to addr 0x10, then read 0x10 next cycle -> `rsp_valid` high one cycle after accept, `rsp_data` = 0xA5.
- Back-to-back reads of 0x00..0x03 with `rsp_ready` = 1 (prefilled 1,2,3,4) -> responses 1,2,3,4 on consecutive cycles, no bubbles.
- Read of 0x20 (holds 0x5A) with `rsp_ready` = 0 for 5 cycles -> `rsp_data` stable at 0x5A, `req_ready` low until `rsp_ready` rises, then a new read is accepted the same cycle.
- Fill the RAM with nonzero data, then pulse `clr_start` -> `clr_busy` high for exactly 256 cycles (ADDR_WIDTH = 8); reads of 0x00, 0x7F and 0xFF return 0; a request held during clear is accepted the cycle after `clr_busy` falls.
- Assert `rst_n` = 0 at clear cycle 100 -> all outputs 0 next edge; after release, addr 99 reads 0 and addr 200 reads its old nonzero value.
- Build without `RAM_CTRL_CLEAR_EN` -> the module elaborates without `clr_*` ports and the first two scenarios pass unchanged.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types and sizing helpers for ram_ctrl.
// State encoding for the request/clear FSM and the RAM depth derivation.
// No ports; imported by ram_ctrl.
package ram_ctrl_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int DEF_ADDR_WIDTH = 8;

    // Number of words addressable by an address of the given width.
    function automatic int ram_depth(input int aw);
        return 1 << aw;
    endfunction

    localparam int DEF_DEPTH = ram_depth(DEF_ADDR_WIDTH);

endpackage

// File: rtl/ram_ctrl.sv
// Request front-end for a single-port async-read RAM: valid/ready requests in, one-entry response slot out.
// Latency: writes land at the acceptance edge; read data is valid the cycle after acceptance.
// Backpressure: req_ready drops while the response slot is full and not draining, or while clearing.
//
// Optional build macro RAM_CTRL_CLEAR_EN adds clr_start/clr_busy and a hardware
// sequence that writes zero to every RAM word, one word per cycle.
// Ports: req_* (request in), rsp_* (read response out), clr_* (clear control,
// macro only), ram_* (to/from the ram block; ram_d_out is a combinational read).
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
`ifdef RAM_CTRL_CLEAR_EN
    input  logic                  clr_start,
    output logic                  clr_busy,
`endif
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_d_in,
    input  logic [DATA_WIDTH-1:0] ram_d_out
);

    logic                  slot_free;
    logic                  accept;
    logic                  clearing;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;

    // Slot can take new data if empty or being drained this cycle.
    assign slot_free = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;

`ifdef RAM_CTRL_CLEAR_EN
    localparam int DEPTH = ram_depth(ADDR_WIDTH);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                // Counter wraps naturally back to 0 after the last word.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // clr_start wins over a same-cycle request.
    assign req_ready = rst_n && (state_q == ST_IDLE) && slot_free && !clr_start;
    assign clearing  = (state_q == ST_CLEAR);
    assign clr_addr  = cnt_q;
    assign clr_busy  = clearing;
`else
    assign req_ready = rst_n && slot_free;
    assign clearing  = 1'b0;
    assign clr_addr  = '0;
`endif

    // RAM drive. Address/data hold their last driven value when idle; write
    // enable is gated by reset so a reset landing mid-clear never writes.
    always_comb begin
        ram_wr_en = 1'b0;
        ram_addr  = addr_q;
        ram_d_in  = din_q;
        if (clearing && rst_n) begin
            ram_wr_en = 1'b1;
            ram_addr  = clr_addr;
            ram_d_in  = '0;
        end else if (accept) begin
            ram_wr_en = req_we;
            ram_addr  = req_addr;
            if (req_we) ram_d_in = req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q    <= '0;
            din_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            addr_q <= ram_addr;
            din_q  <= ram_d_in;
            if (accept && !req_we) begin
                rsp_valid <= 1'b1;
                rsp_data  <= ram_d_out;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
